// File: rtl/img_reader.sv
`timescale 1ns/1ps
// Small fall-through FIFO: an arriving word is visible at the head in the same cycle when empty.
// Latency 0 clk through an empty FIFO, 1 clk once occupied.
// Backpressure: the producer must hold off when cnt_o reaches DEPTH; there is no full-side stall.
module img_reader_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_vld_i,
    input  logic [WIDTH-1:0]           push_dat_i,
    input  logic                       pop_rdy_i,
    output logic                       pop_vld_o,
    output logic [WIDTH-1:0]           pop_dat_o,
    output logic [$clog2(DEPTH+1)-1:0] cnt_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [CW-1:0]    cnt_q;
    logic             empty;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    // A word that arrives into an empty FIFO and is taken in the same cycle is never stored.
    assign wr_en     = push_vld_i && !(empty && pop_rdy_i);
    assign rd_en     = pop_rdy_i && !empty;
    assign pop_vld_o = !empty || push_vld_i;
    assign pop_dat_o = empty ? push_dat_i : mem_q[rd_q];
    assign cnt_o     = cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= ptr_inc(wr_q);
            if (rd_en) rd_q <= ptr_inc(rd_q);
            cnt_q <= cnt_q + CW'(wr_en) - CW'(rd_en);
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_q] <= push_dat_i;
    end
endmodule

// Frame reader: walks img_mem in raster order and streams pixels out with SOF/EOL/EOF tags.
// Latency: start -> first m_valid_o is 2 clk; 1 pixel/clk with m_ready_i=1 and w_busy_i=0.
// Backpressure: reads are issued only while in-flight + buffered < 2, so m_ready_i stalls never drop data.
module img_reader #(
    parameter int  IMG_WIDTH  = 640,
    parameter int  IMG_HEIGHT = 480,
    parameter int  DATA_WIDTH = 8,
    localparam int PIXELS     = IMG_WIDTH * IMG_HEIGHT,
    localparam int AW         = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  w_busy_i,
    output logic [AW-1:0]         r_addr_o,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic                  m_sof_o,
    output logic                  m_eol_o,
    output logic                  m_eof_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int HW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int VW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    typedef struct packed {
        logic sof;
        logic eol;
        logic eof;
    } tag_t;

    typedef struct packed {
        tag_t                  tag;
        logic [DATA_WIDTH-1:0] dat;
    } beat_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   issue_cnt_q, issue_cnt_d;
    logic [AW-1:0]   r_addr_q, r_addr_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic            inflight_q, inflight_d;
    tag_t            tag_q, tag_d;
    logic            done_q, done_d;

    beat_t           ret_beat;
    beat_t           head;
    logic            head_vld;
    logic            pop;
    logic [1:0]      fifo_cnt;
    logic            credit_ok;
    logic            last_addr;
    logic            last_col;

    assign last_addr = (issue_cnt_q == AW'(PIXELS - 1));
    assign last_col  = (h_q == HW'(IMG_WIDTH - 1));
    assign credit_ok = (({1'b0, inflight_q} + fifo_cnt) < 2'd2);
    assign pop       = head_vld && m_ready_i;

    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        h_d         = h_q;
        v_d         = v_q;
        r_addr_d    = r_addr_q;
        tag_d       = tag_q;
        inflight_d  = 1'b0;
        done_d      = pop && head.tag.eof;

        unique case (state_q)
            S_IDLE: begin
                // done_q still high means the previous frame just closed; a start here is dropped.
                if (start_i && !done_q) begin
                    state_d     = S_RUN;
                    issue_cnt_d = '0;
                    h_d         = '0;
                    v_d         = '0;
                end
            end
            S_RUN: begin
                if (!w_busy_i && credit_ok) begin
                    inflight_d = 1'b1;
                    r_addr_d   = issue_cnt_q;
                    tag_d.sof  = (h_q == '0) && (v_q == '0);
                    tag_d.eol  = last_col;
                    tag_d.eof  = last_addr;
                    if (last_addr) begin
                        state_d = S_DRAIN;
                    end else begin
                        issue_cnt_d = issue_cnt_q + 1'b1;
                        if (last_col) begin
                            h_d = '0;
                            v_d = v_q + 1'b1;
                        end else begin
                            h_d = h_q + 1'b1;
                        end
                    end
                end
            end
            S_DRAIN: begin
                if (pop && head.tag.eof) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            issue_cnt_q <= '0;
            h_q         <= '0;
            v_q         <= '0;
            r_addr_q    <= '0;
            inflight_q  <= 1'b0;
            tag_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            h_q         <= h_d;
            v_q         <= v_d;
            r_addr_q    <= r_addr_d;
            inflight_q  <= inflight_d;
            tag_q       <= tag_d;
            done_q      <= done_d;
        end
    end

    // din_i belongs to the read issued last cycle; its tags were captured at issue time.
    assign ret_beat = {tag_q, din_i};

    img_reader_fifo #(
        .WIDTH ($bits(beat_t)),
        .DEPTH (2)
    ) u_ret_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_vld_i (inflight_q),
        .push_dat_i (ret_beat),
        .pop_rdy_i  (m_ready_i),
        .pop_vld_o  (head_vld),
        .pop_dat_o  (head),
        .cnt_o      (fifo_cnt)
    );

    assign r_addr_o  = r_addr_d;
    assign m_valid_o = head_vld;
    assign m_data_o  = head_vld ? head.dat : '0;
    assign m_sof_o   = head_vld && head.tag.sof;
    assign m_eol_o   = head_vld && head.tag.eol;
    assign m_eof_o   = head_vld && head.tag.eof;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
endmodule

// File: tb/tb_img_reader.sv
`timescale 1ns/1ps
// Bench for img_reader on a 4x3 frame; img_mem is modelled as mem[a] = a + 8'h10 with a 1-cycle read.
module tb_img_reader;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int DW = 8;
    localparam int AW = $clog2(N);

    typedef struct packed {
        logic [DW-1:0] dat;
        logic          sof;
        logic          eol;
        logic          eof;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          w_busy = 1'b0;
    logic          m_ready = 1'b0;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] din = '0;
    logic [DW-1:0] m_data;
    logic          m_valid, m_sof, m_eol, m_eof, busy, done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;

    beat_t         got_q[$];
    int            got_t[$];
    logic          eof_acc_last = 1'b0;
    logic          prev_stall = 1'b0;
    logic          prev_rst = 1'b1;
    beat_t         prev_beat = '0;
    logic [AW-1:0] prev_addr = '0;

    img_reader #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .DATA_WIDTH (DW)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .w_busy_i  (w_busy),
        .r_addr_o  (r_addr),
        .din_i     (din),
        .m_data_o  (m_data),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_sof_o   (m_sof),
        .m_eol_o   (m_eol),
        .m_eof_o   (m_eof),
        .busy_o    (busy),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    // img_mem read port: disabled while a write is in progress.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!w_busy) din <= 8'(r_addr) + 8'h10;
    end

    function automatic beat_t exp_beat(input int k);
        beat_t b;
        b.dat = DW'(k + 'h10);
        b.sof = (k == 0);
        b.eol = ((k % W) == W - 1);
        b.eof = (k == N - 1);
        return b;
    endfunction

    // Stream monitor: records accepted beats and checks done timing, stall stability, and addr hold.
    always @(negedge clk) begin
        beat_t cur;
        cur = {m_data, m_sof, m_eol, m_eof};
        if (rst) begin
            prev_stall   = 1'b0;
            eof_acc_last = 1'b0;
            prev_rst     = 1'b1;
        end else begin
            n_cmp++;
            assert (done === eof_acc_last) else begin
                n_err++;
                $error("FAIL done_pulse got %b exp %b at cyc %0d", done, eof_acc_last, cyc);
            end
            if (done) done_cnt++;
            if (prev_stall) begin
                n_cmp++;
                assert (m_valid && (cur === prev_beat)) else begin
                    n_err++;
                    $error("FAIL stall_hold got v=%b %h exp v=1 %h", m_valid, cur, prev_beat);
                end
            end
            if (w_busy && !prev_rst) begin
                n_cmp++;
                assert (r_addr === prev_addr) else begin
                    n_err++;
                    $error("FAIL busy_addr_hold got %0d exp %0d", r_addr, prev_addr);
                end
            end
            if (m_valid && m_ready) begin
                got_q.push_back(cur);
                got_t.push_back(cyc);
            end
            prev_stall   = m_valid && !m_ready;
            prev_beat    = cur;
            eof_acc_last = m_valid && m_ready && m_eof;
            prev_addr    = r_addr;
            prev_rst     = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        n_cmp++;
        assert (got_q.size() === N) else begin
            n_err++;
            $error("FAIL %s beat_count got %0d exp %0d", tag, got_q.size(), N);
        end
        for (int k = 0; k < N && k < got_q.size(); k++) begin
            n_cmp++;
            assert (got_q[k] === exp_beat(k)) else begin
                n_err++;
                $error("FAIL %s beat%0d got %h exp %h", tag, k, got_q[k], exp_beat(k));
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start   = 1'b1;
        m_ready = 1'b1;
        w_busy  = 1'b0;
    endtask

    // Drives one frame until done (or abort by reset), with optional busy burst, restarts and ready noise.
    task automatic run_frame(input bit rnd, input int busy_at, input int restart_at,
                             input bit start_on_done, input int rst_at);
        int d0 = done_cnt;
        int busy_left = 0;
        int n = 0;
        bit busy_fired = 0;
        bit restarted = 0;
        while (1) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cnt != d0) break;
            n++;
            if (n > 400) begin
                n_cmp++;
                n_err++;
                $error("FAIL frame_timeout got %0d beats exp %0d", got_q.size(), N);
                break;
            end
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (busy_left > 0) begin
                w_busy = 1'b1;
                busy_left--;
            end else begin
                w_busy = 1'b0;
            end
            if (!busy_fired && got_q.size() == busy_at) begin
                busy_fired = 1;
                w_busy     = 1'b1;
                busy_left  = 2;
            end
            if (!restarted && got_q.size() == restart_at) begin
                restarted = 1;
                start     = 1'b1;
            end
            if (start_on_done && eof_acc_last) start = 1'b1;
            if (got_q.size() == rst_at) begin
                #1 rst = 1'b1;
                #1 chk("rst_outputs_zero", 32'({r_addr, m_data, m_valid, m_sof, m_eol, m_eof, busy, done}), 32'h0);
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int d5;
        #1 rst = 1'b1;
        #1 chk("reset_outputs", 32'({r_addr, m_data, m_valid, m_sof, m_eol, m_eof, busy, done}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // 1: back-to-back frame, latency and spacing
        got_q.delete(); got_t.delete();
        pulse_start();
        @(negedge clk); chk("t1_lat_c0", 32'(m_valid), 32'h0);
        @(posedge clk); #1 start = 1'b0;
        chk("t1_busy_run", 32'(busy), 32'h1);
        @(negedge clk); chk("t1_lat_c1", 32'(m_valid), 32'h0);
        @(negedge clk); chk("t1_lat_c2", 32'({m_valid, m_data, m_sof}), 32'({1'b1, 8'h10, 1'b1}));
        run_frame(1'b0, -1, -1, 1'b0, -1);
        check_frame("t1");
        if (got_t.size() == N) chk("t1_consecutive", 32'(got_t[N-1] - got_t[0]), 32'(N - 1));
        chk("t1_busy_idle", 32'(busy), 32'h0);

        // 2: random backpressure, two frames
        for (int f = 0; f < 2; f++) begin
            got_q.delete(); got_t.delete();
            pulse_start();
            run_frame(1'b1, -1, -1, 1'b0, -1);
            check_frame("t2");
        end

        // 3: write in progress when start arrives
        got_q.delete(); got_t.delete();
        @(posedge clk); #1;
        start = 1'b1; w_busy = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); chk("t3_no_beat_busy", 32'(m_valid), 32'h0);
            @(posedge clk); #1 start = 1'b0;
        end
        w_busy = 1'b0;
        run_frame(1'b0, -1, -1, 1'b0, -1);
        check_frame("t3");

        // 4: write burst after beat 5
        got_q.delete(); got_t.delete();
        pulse_start();
        run_frame(1'b0, 6, -1, 1'b0, -1);
        check_frame("t4");

        // 5: start mid-frame and coincident with done
        got_q.delete(); got_t.delete();
        d5 = done_cnt;
        pulse_start();
        run_frame(1'b0, -1, 4, 1'b1, -1);
        repeat (10) @(posedge clk);
        #1;
        check_frame("t5");
        chk("t5_one_done", 32'(done_cnt - d5), 32'h1);
        chk("t5_idle", 32'(busy), 32'h0);

        // 6: reset after beat 6, then a clean frame
        got_q.delete(); got_t.delete();
        pulse_start();
        run_frame(1'b1, -1, -1, 1'b0, 7);
        got_q.delete(); got_t.delete();
        pulse_start();
        run_frame(1'b0, -1, -1, 1'b0, -1);
        check_frame("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
